// File: rtl/tt_sweep_reader.sv
// tt_sweep_reader: reads back the 8-bit truth-table code of a 3-input gate.
// It steps the gate through all 8 input vectors and lets each one settle
// for SETTLE_CYCLES clocks. It then samples the gate output and assembles
// a Wolfram-style code, where bit (7-k) is the output for input vector k.
// At the end it compares that code against an expected code latched at start.
module tt_sweep_reader #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       expected,
  output logic [2:0]       dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       tt_code,
  output logic             match,
  output logic [7:0]       mismatch_mask
);

  // Reload value: a vector is sampled on the edge where the counter is
  // already zero, so loading SETTLE_CYCLES-1 gives SETTLE_CYCLES edges per vector.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FINISH
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       exp_q;

  // Sweep controller: the only sequential block. Every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 3'd0;
      cnt           <= '0;
      exp_q         <= 8'h00;
      dut_in        <= 3'b000;
      busy          <= 1'b0;
      done          <= 1'b0;
      tt_code       <= 8'h00;
      match         <= 1'b0;
      mismatch_mask <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            exp_q         <= expected;
            tt_code       <= 8'h00;
            match         <= 1'b0;
            mismatch_mask <= 8'h00;
            idx           <= 3'd0;
            dut_in        <= 3'b000;
            cnt           <= RELOAD;
            busy          <= 1'b1;
            state         <= SWEEP;
          end
        end
        SWEEP: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            dut_in <= 3'b000;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            tt_code[3'd7 - idx] <= dut_out;
            if (idx != 3'd7) begin
              idx    <= idx + 3'd1;
              dut_in <= idx + 3'd1;
              cnt    <= RELOAD;
            end else begin
              state  <= FINISH;
              dut_in <= 3'b000;
            end
          end
        end
        FINISH: begin
          match         <= (tt_code == exp_q);
          mismatch_mask <= tt_code ^ exp_q;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Directed bench for tt_sweep_reader, built around three instances.
// The main instance uses SETTLE_CYCLES=4 and drives a combinational 0xB2 gate.
// Two side instances use SETTLE_CYCLES=1 and 3 and drive a 0xB2 gate whose
// output lags its input by two clocks.
module tb_tt_sweep_reader;

  logic clk;
  logic rst_n;

  // main instance signals
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [2:0] dutIn;
  logic       dutOut;
  logic       busy;
  logic       done;
  logic [7:0] ttCode;
  logic       match;
  logic [7:0] mismatchMask;

  // slow-gate instance signals
  logic       startB;
  logic [2:0] dutIn1, dutIn3;
  logic       dutOut1, dutOut3;
  logic       busy1, busy3, done1, done3, match1, match3;
  logic [7:0] ttCode1, ttCode3, mm1, mm3;
  logic [2:0] d1a, d1b, d3a, d3b;

  int checkCount;
  int errorCount;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference gate: output for vector v is bit (7-v) of 0xB2
  function automatic logic gateB2(input logic [2:0] v);
    logic [7:0] code;
    code = 8'hB2;
    return code[3'd7 - v];
  endfunction

  // combinational gate for the main instance
  always_comb dutOut = gateB2(dutIn);

  // two-cycle-lagged gates for the side instances
  always_ff @(posedge clk) begin
    d1a <= dutIn1;
    d1b <= d1a;
    d3a <= dutIn3;
    d3b <= d3a;
  end
  always_comb dutOut1 = gateB2(d1b);
  always_comb dutOut3 = gateB2(d3b);

  tt_sweep_reader #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .dut_in(dutIn), .dut_out(dutOut), .busy(busy), .done(done), .tt_code(ttCode),
    .match(match), .mismatch_mask(mismatchMask)
  );

  tt_sweep_reader #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startB), .abort(1'b0), .expected(8'hB2),
    .dut_in(dutIn1), .dut_out(dutOut1), .busy(busy1), .done(done1), .tt_code(ttCode1),
    .match(match1), .mismatch_mask(mm1)
  );

  tt_sweep_reader #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(startB), .abort(1'b0), .expected(8'hB2),
    .dut_in(dutIn3), .dut_out(dutOut3), .busy(busy3), .done(done3), .tt_code(ttCode3),
    .match(match3), .mismatch_mask(mm3)
  );

  // single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
    checkCount++;
    if (observed !== required) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, required, $time);
    end
  endtask

  // pulse start for one edge; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [7:0] exp);
    start    = 1'b1;
    expected = exp;
    @(negedge clk);
    start = 1'b0;
  endtask

  // wait, with a bound, until done is seen; n = negedges waited
  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", done, 1'b1);
  endtask

  // full sweep with result and one-cycle done checks
  task automatic runSweep(input logic [7:0] exp, input logic [7:0] code, input logic m, input logic [7:0] mm);
    int n;
    applyStimulus(exp);
    waitDone(n);
    checkOutput("latency", n, 33);
    checkOutput("ttCode", ttCode, code);
    checkOutput("match", match, m);
    checkOutput("mismatchMask", mismatchMask, mm);
    checkOutput("busyAtDone", busy, 1'b0);
    @(negedge clk);
    checkOutput("doneOneCycle", done, 1'b0);
    checkOutput("matchHeld", match, m);
  endtask

  initial begin
    int n;
    int doneSeen;
    checkCount = 0;
    errorCount = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    startB   = 1'b0;
    expected = 8'h00;
    repeat (3) @(negedge clk);

    // reset values
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstDutIn", dutIn, 3'b000);
    checkOutput("rstTtCode", ttCode, 8'h00);
    checkOutput("rstMatch", match, 1'b0);
    checkOutput("rstMask", mismatchMask, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // slow gate at SETTLE_CYCLES=1 captures stale samples; at 3 it reads correctly
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    n = 0;
    while ((busy1 || busy3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("slowIdle", {busy1, busy3}, 2'b00);
    checkOutput("settle1Code", ttCode1, 8'hEC);
    checkOutput("settle1Match", match1, 1'b0);
    checkOutput("settle1Mask", mm1, 8'h5E);
    checkOutput("settle3Code", ttCode3, 8'hB2);
    checkOutput("settle3Match", match3, 1'b1);

    // matching sweep
    runSweep(8'hB2, 8'hB2, 1'b1, 8'h00);

    // mismatching sweep with per-cycle dut_in trace
    applyStimulus(8'hB3);
    for (int j = 0; j < 32; j++) begin
      checkOutput($sformatf("dutInCycle%0d", j), dutIn, j / 4);
      checkOutput("busySweep", busy, 1'b1);
      @(negedge clk);
    end
    checkOutput("dutInFinish", dutIn, 3'b000);
    waitDone(n);
    checkOutput("ttCodeB3", ttCode, 8'hB2);
    checkOutput("matchB3", match, 1'b0);
    checkOutput("maskB3", mismatchMask, 8'h01);
    @(negedge clk);

    // abort ten cycles into a sweep
    applyStimulus(8'hB2);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortBusy", busy, 1'b0);
    checkOutput("abortDutIn", dutIn, 3'b000);
    checkOutput("abortTtCode", ttCode, 8'h80);
    checkOutput("abortMatch", match, 1'b0);
    checkOutput("abortMask", mismatchMask, 8'h00);
    doneSeen = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("abortNoDone", doneSeen, 0);

    // start together with abort in idle is refused
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbortBusy", busy, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("startAbortIdle", busy, 1'b0);
    checkOutput("startAbortTt", ttCode, 8'h80);

    // abort during the finish cycle is ignored
    applyStimulus(8'hB2);
    repeat (32) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("finishAbortDone", done, 1'b1);
    checkOutput("finishAbortMatch", match, 1'b1);
    @(negedge clk);

    // start and expected changes while busy are ignored
    applyStimulus(8'hB2);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    expected = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    expected = 8'h5A;
    waitDone(n);
    checkOutput("ignoreLatency", n, 20);
    checkOutput("ignoreMatch", match, 1'b1);
    checkOutput("ignoreMask", mismatchMask, 8'h00);

    // back-to-back start on the done cycle
    start    = 1'b1;
    expected = 8'hB3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2bDoneLow", done, 1'b0);
    checkOutput("b2bBusy", busy, 1'b1);
    checkOutput("b2bCleared", match, 1'b0);
    waitDone(n);
    checkOutput("b2bLatency", n, 33);
    checkOutput("b2bMask", mismatchMask, 8'h01);
    @(negedge clk);

    // asynchronous reset mid-sweep
    applyStimulus(8'hB2);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", busy, 1'b0);
    checkOutput("asyncDutIn", dutIn, 3'b000);
    checkOutput("asyncTtCode", ttCode, 8'h00);
    checkOutput("asyncDone", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runSweep(8'hB2, 8'hB2, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
